// File: rtl/lpc_pkg.sv
// Shared constants and state encoding for the LPC analysis frame path.
package lpc_pkg;

  localparam int LPC_FRAME_LEN = 160;
  localparam int LPC_ORDER     = 10;
  localparam int LPC_DATA_W    = 16;
  localparam int LPC_LAG_W     = 4;

  typedef enum logic [1:0] {
    FILL,
    RD_A,
    RD_B,
    OUT
  } state_t;

endpackage

// File: rtl/frame_buf_ctrl_if.sv
// Sample stream, register-file port pair and operand-pair stream of frame_buf_ctrl.
interface frame_buf_ctrl_if
  import lpc_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = LPC_DATA_W
);

  logic                 s_valid;
  logic                 s_ready;
  logic [DATA_W-1:0]    s_data;

  logic                 rf_wen;
  logic [ADDR_W-1:0]    rf_waddr;
  logic [DATA_W-1:0]    rf_din;
  logic [ADDR_W-1:0]    rf_raddr;
  logic [DATA_W-1:0]    rf_dout;

  logic                 p_valid;
  logic                 p_ready;
  logic [DATA_W-1:0]    p_a;
  logic [DATA_W-1:0]    p_b;
  logic [LPC_LAG_W-1:0] p_lag;
  logic                 p_last_lag;
  logic                 p_last;

  logic                 busy;

  modport master (
    input  s_valid, s_data, rf_dout, p_ready,
    output s_ready, rf_wen, rf_waddr, rf_din, rf_raddr,
           p_valid, p_a, p_b, p_lag, p_last_lag, p_last, busy
  );

  modport slave (
    output s_valid, s_data, rf_dout, p_ready,
    input  s_ready, rf_wen, rf_waddr, rf_din, rf_raddr,
           p_valid, p_a, p_b, p_lag, p_last_lag, p_last, busy
  );

endinterface

// File: rtl/acf_addr_gen.sv
// n/k sweep counters for the autocorrelation replay: n runs 0..FRAME_LEN-1-k per lag k.
// Latency: counters step one cycle after advance; nk and flags are combinational from n/k.
// Backpressure: holds whenever advance is low.
module acf_addr_gen
  import lpc_pkg::*;
#(
  parameter int FRAME_LEN = LPC_FRAME_LEN,
  parameter int ORDER     = LPC_ORDER,
  parameter int ADDR_W    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 advance,
  output logic [ADDR_W-1:0]    n,
  output logic [LPC_LAG_W-1:0] k,
  output logic [ADDR_W-1:0]    nk,
  output logic                 last_lag,
  output logic                 last
);

  logic [ADDR_W-1:0] n_end;

  assign n_end    = ADDR_W'(FRAME_LEN - 1) - ADDR_W'(k);
  assign nk       = n + ADDR_W'(k);
  assign last_lag = (n == n_end);
  assign last     = last_lag && (k == LPC_LAG_W'(ORDER));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      n <= '0;
      k <= '0;
    end else if (clear) begin
      n <= '0;
      k <= '0;
    end else if (advance) begin
      // Wrapping to zero after the final pair leaves the counters ready for the next frame.
      if (last) begin
        n <= '0;
        k <= '0;
      end else if (last_lag) begin
        n <= '0;
        k <= k + 1'b1;
      end else begin
        n <= n + 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_buf_ctrl.sv
// Fills the sample register file with one frame, then replays it as (x[n], x[n+k]) pairs.
// Latency: first pair valid 2 cycles after sweep start, then one pair per 3 cycles.
// Backpressure: s_ready low for the whole sweep; p_ready low holds the pair indefinitely.
module frame_buf_ctrl
  import lpc_pkg::*;
#(
  parameter int FRAME_LEN = LPC_FRAME_LEN,
  parameter int ORDER     = LPC_ORDER,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = LPC_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  frame_buf_ctrl_if.master  bus
);

  state_t                 state;
  logic [ADDR_W-1:0]      wcnt;
  logic [ADDR_W-1:0]      raddr_q;
  logic [DATA_W-1:0]      a_q;
  logic [DATA_W-1:0]      b_q;
  logic [LPC_LAG_W-1:0]   lag_q;
  logic                   last_lag_q;
  logic                   last_q;

  logic                   accept;
  logic                   clear;
  logic                   advance;
  logic [ADDR_W-1:0]      n;
  logic [LPC_LAG_W-1:0]   k;
  logic [ADDR_W-1:0]      nk;
  logic                   last_lag;
  logic                   last;

  assign bus.s_ready  = (state == FILL);
  assign accept       = bus.s_valid & bus.s_ready;
  assign bus.rf_wen   = accept;
  assign bus.rf_waddr = wcnt;
  assign bus.rf_din   = bus.s_data;

  assign clear   = accept && (wcnt == ADDR_W'(FRAME_LEN - 1));
  assign advance = (state == OUT) && bus.p_ready;

  assign bus.p_valid    = (state == OUT);
  assign bus.p_a        = a_q;
  assign bus.p_b        = b_q;
  assign bus.p_lag      = lag_q;
  assign bus.p_last_lag = last_lag_q;
  assign bus.p_last     = last_q;
  assign bus.busy       = (state != FILL);

  // The register file reads combinationally, so the address must be live in the read states.
  always_comb begin
    bus.rf_raddr = raddr_q;
    if (state == RD_A) begin
      bus.rf_raddr = n;
    end else if (state == RD_B) begin
      bus.rf_raddr = nk;
    end
  end

  acf_addr_gen #(
    .FRAME_LEN (FRAME_LEN),
    .ORDER     (ORDER),
    .ADDR_W    (ADDR_W)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .clear    (clear),
    .advance  (advance),
    .n        (n),
    .k        (k),
    .nk       (nk),
    .last_lag (last_lag),
    .last     (last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= FILL;
      wcnt       <= '0;
      raddr_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      lag_q      <= '0;
      last_lag_q <= 1'b0;
      last_q     <= 1'b0;
    end else begin
      raddr_q <= bus.rf_raddr;
      case (state)
        FILL: begin
          if (accept) begin
            if (clear) begin
              wcnt  <= '0;
              state <= RD_A;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        RD_A: begin
          a_q   <= bus.rf_dout;
          state <= RD_B;
        end
        RD_B: begin
          b_q        <= bus.rf_dout;
          lag_q      <= k;
          last_lag_q <= last_lag;
          last_q     <= last;
          state      <= OUT;
        end
        OUT: begin
          if (bus.p_ready) begin
            state <= last_q ? FILL : RD_A;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_buf_ctrl.sv
// Directed bench for frame_buf_ctrl with a behavioural register file beside the DUT.
module tb_frame_buf_ctrl;

  localparam int FL  = 160;
  localparam int ORD = 10;
  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int PAIRS = (ORD + 1) * FL - (ORD * (ORD + 1)) / 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  frame_buf_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  frame_buf_ctrl #(
    .FRAME_LEN (FL),
    .ORDER     (ORD),
    .ADDR_W    (AW),
    .DATA_W    (DW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.rf_wen === 1'b1) mem[bus.rf_waddr] <= bus.rf_din;
  end
  assign bus.rf_dout = mem[bus.rf_raddr];

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic pick(input int stall);
    if (stall == 0) return 1'b1;
    return int'($urandom_range(99)) >= stall;
  endfunction

  // Streams one frame starting in the current cycle; leaves the DUT in RD_A.
  task automatic fill(input bit ramp, input logic [DW-1:0] cval);
    for (int i = 0; i < FL; i++) begin
      bus.s_valid = 1'b1;
      bus.s_data  = ramp ? DW'(i) : cval;
      #1;
      chk("fill_s_ready", bus.s_ready, 1);
      chk("fill_rf_wen", bus.rf_wen, 1);
      chk("fill_rf_waddr", bus.rf_waddr, i);
      chk("fill_busy", bus.busy, 0);
      @(posedge clk); #1;
    end
    bus.s_data = 16'hDEAD;
    chk("sweep_busy", bus.busy, 1);
    chk("sweep_s_ready", bus.s_ready, 0);
    chk("sweep_p_valid_rd_a", bus.p_valid, 0);
  endtask

  // Consumes the pair stream against an independent n/k model.
  task automatic sweep(input int stall, input bit ramp, input logic [DW-1:0] cval,
                       input int abort_at, output int npairs, output int first_wait);
    int n = 0;
    int k = 0;
    int guard;
    bit done = 1'b0;
    bit ll;
    logic [DW-1:0] ea, eb;
    npairs = 0;
    first_wait = -1;
    while (!done && k <= ORD) begin
      guard = 0;
      while (bus.p_valid !== 1'b1 && guard < 8) begin
        bus.p_ready = pick(stall);
        @(posedge clk); #1;
        guard++;
      end
      if (npairs == 0 && first_wait < 0) first_wait = guard;
      if (bus.p_valid !== 1'b1) begin
        chk("pair_timeout", bus.p_valid, 1);
        done = 1'b1;
      end else begin
        ll = (n == FL - 1 - k);
        ea = ramp ? DW'(n) : cval;
        eb = ramp ? DW'(n + k) : cval;
        chk("p_a", bus.p_a, ea);
        chk("p_b", bus.p_b, eb);
        chk("p_lag", bus.p_lag, k);
        chk("p_last_lag", bus.p_last_lag, ll);
        chk("p_last", bus.p_last, ll && (k == ORD));
        chk("sweep_no_accept", bus.rf_wen, 0);
        if (npairs == abort_at) begin
          done = 1'b1;
        end else begin
          bus.p_ready = pick(stall);
          if (bus.p_ready) begin
            npairs++;
            if (ll) begin
              n = 0;
              k++;
            end else begin
              n++;
            end
          end
          @(posedge clk); #1;
        end
      end
    end
  endtask

  initial begin
    int np, fw, t0;
    reset       = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.p_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_ready", bus.s_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rf_wen", bus.rf_wen, 0);
    chk("rst_p_valid", bus.p_valid, 0);
    chk("rst_rf_waddr", bus.rf_waddr, 0);
    chk("rst_rf_raddr", bus.rf_raddr, 0);
    chk("rst_p_a", bus.p_a, 0);
    chk("rst_p_b", bus.p_b, 0);
    chk("rst_p_lag", bus.p_lag, 0);
    chk("rst_p_last_lag", bus.p_last_lag, 0);
    chk("rst_p_last", bus.p_last, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_s_ready", bus.s_ready, 1);
    chk("idle_rf_wen", bus.rf_wen, 0);

    // Frame 1: ramp, no stalls, upstream keeps s_valid high during the sweep.
    fill(1'b1, '0);
    t0 = cyc;
    sweep(0, 1'b1, '0, -1, np, fw);
    chk("f1_pairs", np, PAIRS);
    chk("f1_first_wait", fw, 2);
    chk("f1_sweep_cycles", cyc - t0, 3 * PAIRS);
    chk("f1_end_busy", bus.busy, 0);
    chk("f1_end_s_ready", bus.s_ready, 1);
    chk("b2b_rf_wen", bus.rf_wen, 1);
    chk("b2b_waddr0", bus.rf_waddr, 0);

    // Frame 2: back-to-back ramp with 50% random p_ready backpressure.
    fill(1'b1, '0);
    sweep(50, 1'b1, '0, -1, np, fw);
    chk("f2_pairs", np, PAIRS);
    chk("f2_end_s_ready", bus.s_ready, 1);

    // Frame 3: ramp, reset while pair 800 is presented.
    fill(1'b1, '0);
    sweep(0, 1'b1, '0, 800, np, fw);
    chk("f3_pairs_before_reset", np, 800);
    bus.s_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_rst_p_valid", bus.p_valid, 0);
    chk("mid_rst_s_ready", bus.s_ready, 1);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_rf_wen", bus.rf_wen, 0);
    chk("mid_rst_rf_waddr", bus.rf_waddr, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Frame 4: constant 0x7FFF after the abort.
    fill(1'b0, 16'h7FFF);
    sweep(0, 1'b0, 16'h7FFF, -1, np, fw);
    chk("f4_pairs", np, PAIRS);
    chk("f4_end_s_ready", bus.s_ready, 1);
    bus.s_valid = 1'b0;
    @(posedge clk); #1;
    chk("f4_idle_rf_wen", bus.rf_wen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
